// File: rtl/audio_adc_i2s_receiver_if.sv
// audio_adc_i2s_receiver_if: stereo sample-pair stream from the I2S receiver to its consumer
//   o_left, o_right  signed two's complement pair, stable while o_valid=1 (master drives)
//   o_valid          a pair is available (master drives)
//   i_ready          consumer takes the pair when o_valid & i_ready (slave drives)
interface audio_adc_i2s_receiver_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] o_left;
    logic [DATA_W-1:0] o_right;
    logic              o_valid;
    logic              i_ready;
    modport master (output o_left, output o_right, output o_valid, input i_ready);
    modport slave  (input o_left, input o_right, input o_valid, output i_ready);
endinterface

// File: rtl/audio_adc_i2s_receiver.sv
// audio_adc_i2s_receiver: oversampling I2S/left-justified ADC receiver issuing one stereo pair per LRCK frame
//   clk, reset          system clock, synchronous active-high reset
//   aud_bclk/lrck/adcdat codec serial pins, asynchronous to clk (BCLK <= clk/4)
//   stream (master)     o_left/o_right/o_valid out, i_ready in
//   o_overrun           sticky: a complete pair was dropped while the previous one was still held
//   o_frame_err         sticky: a slot ended before DATA_W bits arrived
//   i_clr_err           one-cycle pulse clearing both sticky flags (a coincident new error wins)
module audio_adc_i2s_receiver #(
    parameter int DATA_W   = 16,
    parameter bit I2S_MODE = 1'b1,
    parameter bit LEFT_LVL = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     aud_bclk,
    input  logic                     aud_lrck,
    input  logic                     aud_adcdat,
    audio_adc_i2s_receiver_if.master stream,
    output logic                     o_overrun,
    output logic                     o_frame_err,
    input  logic                     i_clr_err
);
    localparam int CW = $clog2(DATA_W + 1);
    typedef enum logic [1:0] {SYNC, SKIP, SHIFT, DONE} state_t;
    state_t            state_q, state_d;
    logic [2:0]        bclk_sync_q, bclk_sync_d, lrck_sync_q, lrck_sync_d;
    logic [1:0]        dat_sync_q, dat_sync_d;
    logic              bclk_rise_q, bclk_rise_d, lr_edge_q, lr_edge_d;
    logic              slot_q, slot_d, bit_q, bit_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d, hold_l_q, hold_l_d;
    logic [DATA_W-1:0] left_q, left_d, right_q, right_d;
    logic              left_ok_q, left_ok_d, valid_q, valid_d;
    logic              overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic              take_bit, slot_end, good, is_left, pair, load;

    // Synchronisers run free of reset so a pin level held through reset is never seen as an edge.
    always_ff @(posedge clk) begin
        bclk_sync_q <= bclk_sync_d;
        lrck_sync_q <= lrck_sync_d;
        dat_sync_q  <= dat_sync_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SYNC;
            bclk_rise_q <= 1'b0;
            lr_edge_q   <= 1'b0;
            slot_q      <= 1'b0;
            bit_q       <= 1'b0;
            cnt_q       <= '0;
            shreg_q     <= '0;
            hold_l_q    <= '0;
            left_q      <= '0;
            right_q     <= '0;
            left_ok_q   <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bclk_rise_q <= bclk_rise_d;
            lr_edge_q   <= lr_edge_d;
            slot_q      <= slot_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            hold_l_q    <= hold_l_d;
            left_q      <= left_d;
            right_q     <= right_d;
            left_ok_q   <= left_ok_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // An LRCK edge always restarts a slot; a coincident BCLK rise is consumed by the new slot
    // (as its MSB in left-justified mode, as the skipped bit in I2S mode).
    always_comb begin
        state_d = lr_edge_q ? ((I2S_MODE && !bclk_rise_q) ? SKIP : SHIFT)
                : !bclk_rise_q ? state_q
                : state_q == SKIP ? SHIFT
                : (state_q == SHIFT && cnt_q == CW'(DATA_W - 1)) ? DONE
                : state_q;
    end

    always_comb begin
        bclk_sync_d = {bclk_sync_q[1:0], aud_bclk};
        lrck_sync_d = {lrck_sync_q[1:0], aud_lrck};
        dat_sync_d  = {dat_sync_q[0], aud_adcdat};
        bclk_rise_d = bclk_sync_q[1] & ~bclk_sync_q[2];
        lr_edge_d   = lrck_sync_q[1] ^ lrck_sync_q[2];
        slot_d      = lrck_sync_q[2];
        bit_d       = dat_sync_q[1];
        take_bit    = bclk_rise_q & (lr_edge_q ? !I2S_MODE : state_q == SHIFT);
        shreg_d     = take_bit ? {shreg_q[DATA_W-2:0], bit_q} : shreg_q;
        cnt_d       = lr_edge_q ? CW'(take_bit) : cnt_q + CW'(take_bit);
        slot_end    = lr_edge_q && state_q != SYNC;
        good        = slot_end && state_q == DONE;
        is_left     = slot_q == LEFT_LVL;
        hold_l_d    = (good && is_left) ? shreg_q : hold_l_q;
        // left_ok survives only from a clean left slot to the right slot that follows it
        left_ok_d   = slot_end ? (good && is_left) : left_ok_q;
        pair        = good && !is_left && left_ok_q;
        load        = pair && (!valid_q || stream.i_ready);
        left_d      = load ? hold_l_q : left_q;
        right_d     = load ? shreg_q : right_q;
        valid_d     = load || (valid_q && !stream.i_ready);
        overrun_d   = (pair && !load) || (overrun_q && !i_clr_err);
        frame_err_d = (slot_end && !good) || (frame_err_q && !i_clr_err);
    end

    assign stream.o_left  = left_q;
    assign stream.o_right = right_q;
    assign stream.o_valid = valid_q;
    assign o_overrun      = overrun_q;
    assign o_frame_err    = frame_err_q;
endmodule

// File: tb/tb_audio_adc_i2s_receiver.sv
// tb_audio_adc_i2s_receiver: vector table, corner sequences and random frames against a slot-level model
module tb_audio_adc_i2s_receiver;
    localparam int DATA_W = 16;
    localparam int H      = 4;

    typedef struct {
        bit          i2s;
        bit          coin;
        logic [15:0] lw;
        logic [15:0] rw;
        int          ln;
        int          rn;
        int          npairs;
        logic [31:0] pair;
        logic        ferr;
    } vec_t;

    logic clk = 1'b0, reset = 1'b1, ready = 1'b1;
    logic aud_bclk = 1'b0, aud_lrck = 1'b1, aud_adcdat = 1'b0, i_clr_err = 1'b0;
    logic ovr_i, ferr_i, ovr_l, ferr_l;
    int vectors = 0, miscompares = 0;
    logic [31:0] got_i[$], got_l[$], exp_q[$], g[$];
    vec_t tbl[7];
    logic [15:0] lw, rw;
    int ln, rn, skip;
    bit coin;
    logic ferr_exp;

    audio_adc_i2s_receiver_if #(.DATA_W(DATA_W)) s_i ();
    audio_adc_i2s_receiver_if #(.DATA_W(DATA_W)) s_l ();
    assign s_i.i_ready = ready;
    assign s_l.i_ready = ready;

    audio_adc_i2s_receiver #(.DATA_W(DATA_W), .I2S_MODE(1'b1), .LEFT_LVL(1'b0)) dut (
        .clk(clk), .reset(reset), .aud_bclk(aud_bclk), .aud_lrck(aud_lrck), .aud_adcdat(aud_adcdat),
        .stream(s_i), .o_overrun(ovr_i), .o_frame_err(ferr_i), .i_clr_err(i_clr_err));

    audio_adc_i2s_receiver #(.DATA_W(DATA_W), .I2S_MODE(1'b0), .LEFT_LVL(1'b0)) dut_lj (
        .clk(clk), .reset(reset), .aud_bclk(aud_bclk), .aud_lrck(aud_lrck), .aud_adcdat(aud_adcdat),
        .stream(s_l), .o_overrun(ovr_l), .o_frame_err(ferr_l), .i_clr_err(i_clr_err));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (s_i.o_valid && s_i.i_ready) got_i.push_back({s_i.o_left, s_i.o_right});
        if (s_l.o_valid && s_l.i_ready) got_l.push_back({s_l.o_left, s_l.o_right});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", n, a, e);
        end
    endtask

    function automatic logic [31:0] pair_now(input bit m);
        return m ? {s_i.o_left, s_i.o_right} : {s_l.o_left, s_l.o_right};
    endfunction
    function automatic logic valid_now(input bit m);
        return m ? s_i.o_valid : s_l.o_valid;
    endfunction
    function automatic logic ferr_now(input bit m);
        return m ? ferr_i : ferr_l;
    endfunction
    function automatic logic ovr_now(input bit m);
        return m ? ovr_i : ovr_l;
    endfunction

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 ready = v;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1; ready = 1'b1; i_clr_err = 1'b0;
        aud_bclk = 1'b0; aud_lrck = 1'b1; aud_adcdat = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset = 1'b0;
        got_i.delete();
        got_l.delete();
    endtask

    // One slot of n BCLK periods. Non-coincident: LRCK/data change on BCLK fall, sampled at the rise
    // half a period later. Coincident: LRCK/data change together with the BCLK rise.
    task automatic send_slot(input logic lr, input logic [15:0] w, input int n, input bit i2s, input bit cn);
        int idx;
        for (int k = 0; k < n; k++) begin
            idx = k - int'(i2s);
            @(negedge clk);
            aud_bclk   = cn;
            aud_lrck   = lr;
            aud_adcdat = (idx >= 0 && idx < DATA_W) ? w[DATA_W-1-idx] : 1'($urandom);
            repeat (H) @(negedge clk);
            aud_bclk = !cn;
            repeat (H - 1) @(negedge clk);
        end
    endtask

    task automatic send_frame(input bit i2s, input bit cn, input logic [15:0] l, input logic [15:0] r,
                              input int nl, input int nr);
        send_slot(1'b0, l, nl, i2s, cn);
        send_slot(1'b1, r, nr, i2s, cn);
    endtask

    task automatic close_and_drain(input bit i2s, input bit cn);
        send_slot(1'b0, 16'h0, 2, i2s, cn);
        repeat (16) @(negedge clk);
    endtask

    task automatic check_pairs(input bit m, input string tag);
        if (m) g = got_i; else g = got_l;
        chk({tag, ".npairs"}, g.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < g.size(); i++)
            chk($sformatf("%s.pair%0d", tag, i), g[i], exp_q[i]);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 16'h8001, 16'h7FFE, 17, 17, 1, 32'h8001_7FFE, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 16'hA5A5, 16'h1234, 32, 32, 1, 32'hA5A5_1234, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 16'hA5A5, 16'h1234, 32, 10, 0, 32'h0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16, 16, 1, 32'hFFFF_0000, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 16'h1234, 16'hABCD, 24, 24, 1, 32'h1234_ABCD, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 16'h5A5A, 16'hC3C3, 12, 16, 0, 32'h0, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 16'h1111, 16'h2222, 16, 16, 0, 32'h0, 1'b1};

        foreach (tbl[v]) begin
            do_reset();
            @(negedge clk);
            chk($sformatf("vec%0d.rst_valid", v), valid_now(tbl[v].i2s), 0);
            chk($sformatf("vec%0d.rst_pair", v), pair_now(tbl[v].i2s), 0);
            chk($sformatf("vec%0d.rst_ferr", v), ferr_now(tbl[v].i2s), 0);
            send_frame(tbl[v].i2s, tbl[v].coin, tbl[v].lw, tbl[v].rw, tbl[v].ln, tbl[v].rn);
            close_and_drain(tbl[v].i2s, tbl[v].coin);
            if (tbl[v].i2s) g = got_i; else g = got_l;
            chk($sformatf("vec%0d.npairs", v), g.size(), tbl[v].npairs);
            if (g.size() > 0) chk($sformatf("vec%0d.pair", v), g[0], tbl[v].pair);
            chk($sformatf("vec%0d.ferr", v), ferr_now(tbl[v].i2s), tbl[v].ferr);
            chk($sformatf("vec%0d.ovr", v), ovr_now(tbl[v].i2s), 0);
        end

        // Backpressure: frames 2 and 3 are dropped, frame 1 held, frame 4 follows.
        do_reset();
        set_ready(1'b0);
        send_frame(1'b1, 1'b0, 16'h1, 16'h2, 17, 17);
        send_frame(1'b1, 1'b0, 16'h3, 16'h4, 17, 17);
        send_frame(1'b1, 1'b0, 16'h5, 16'h6, 17, 17);
        send_slot(1'b0, 16'h7, 17, 1'b1, 1'b0);
        chk("ovr.held_valid", s_i.o_valid, 1);
        chk("ovr.held_pair", pair_now(1'b1), 32'h0001_0002);
        chk("ovr.flag", ovr_i, 1);
        set_ready(1'b1);
        send_slot(1'b1, 16'h8, 17, 1'b1, 1'b0);
        close_and_drain(1'b1, 1'b0);
        exp_q = '{32'h0001_0002, 32'h0007_0008};
        check_pairs(1'b1, "ovr");
        chk("ovr.sticky", ovr_i, 1);
        chk("ovr.ferr", ferr_i, 0);

        // Truncated right slot, error clear, next frame clean.
        do_reset();
        send_frame(1'b1, 1'b0, 16'hA5A5, 16'h1234, 32, 10);
        send_slot(1'b0, 16'h1111, 32, 1'b1, 1'b0);
        chk("trunc.ferr_set", ferr_i, 1);
        @(posedge clk); #1 i_clr_err = 1'b1;
        @(posedge clk); #1 i_clr_err = 1'b0;
        @(negedge clk);
        chk("trunc.ferr_clr", ferr_i, 0);
        send_slot(1'b1, 16'h2222, 32, 1'b1, 1'b0);
        close_and_drain(1'b1, 1'b0);
        exp_q = '{32'h1111_2222};
        check_pairs(1'b1, "trunc");
        chk("trunc.ferr_end", ferr_i, 0);

        // Reset pulse in the middle of a right slot.
        do_reset();
        set_ready(1'b0);
        send_frame(1'b1, 1'b0, 16'h000A, 16'h000B, 17, 17);
        send_slot(1'b0, 16'h000C, 17, 1'b1, 1'b0);
        chk("mrst.pre_valid", s_i.o_valid, 1);
        send_slot(1'b1, 16'h000D, 8, 1'b1, 1'b0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("mrst.valid", s_i.o_valid, 0);
        chk("mrst.pair", pair_now(1'b1), 0);
        set_ready(1'b1);
        send_slot(1'b1, 16'h000D, 9, 1'b1, 1'b0);
        send_frame(1'b1, 1'b0, 16'h000E, 16'h000F, 17, 17);
        close_and_drain(1'b1, 1'b0);
        exp_q = '{32'h000E_000F};
        check_pairs(1'b1, "mrst");
        chk("mrst.ferr", ferr_i, 0);

        // Random frames: a pair is expected exactly when both slots carry all DATA_W bits.
        for (int m = 1; m >= 0; m--) begin
            do_reset();
            skip = m;
            coin = (m == 0) && ($urandom_range(0, 1) == 1);
            exp_q.delete();
            ferr_exp = 1'b0;
            for (int f = 0; f < 15; f++) begin
                lw = 16'($urandom);
                rw = 16'($urandom);
                ln = ($urandom_range(0, 4) == 0) ? int'($urandom_range(3, 15 + skip)) : int'($urandom_range(16 + skip, 32));
                rn = ($urandom_range(0, 4) == 0) ? int'($urandom_range(3, 15 + skip)) : int'($urandom_range(16 + skip, 32));
                if (ln >= DATA_W + skip && rn >= DATA_W + skip) exp_q.push_back({lw, rw});
                else ferr_exp = 1'b1;
                send_frame(bit'(m), coin, lw, rw, ln, rn);
            end
            close_and_drain(bit'(m), coin);
            check_pairs(bit'(m), $sformatf("rand_m%0d", m));
            chk($sformatf("rand_m%0d.ferr", m), ferr_now(bit'(m)), ferr_exp);
            chk($sformatf("rand_m%0d.ovr", m), ovr_now(bit'(m)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
